// File: rtl/input_conditioner_if.sv
// Bundles the raw board pins, the CPU ack strobe and the conditioned levels
// seen by the memory-mapped I/O block.
interface input_conditioner_if;
   logic       button_raw;
   logic [3:0] switches_raw;
   logic       ack;
   logic       button_1;
   logic [3:0] switches;
   logic       button_rise;
   logic       button_pressed;

   modport slave (
      input  button_raw,
      input  switches_raw,
      input  ack,
      output button_1,
      output switches,
      output button_rise,
      output button_pressed
   );

   modport master (
      output button_raw,
      output switches_raw,
      output ack,
      input  button_1,
      input  switches,
      input  button_rise,
      input  button_pressed
   );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the push-button and four slide switches; the button
// additionally gets a rise pulse and a sticky pressed flag cleared by ack.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int SYNC_STAGES     = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   input_conditioner_if.slave  bus
);

   localparam int NCH = 5;
   localparam logic [0:0] STABLE  = 1'b0;
   localparam logic [0:0] PENDING = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

   logic [NCH-1:0] raw_all;
   logic [NCH-1:0] level;
   logic           button_q_d;
   logic           rise_r;
   logic           pressed_r;

   // Channel 4 is the button, channels 3..0 are the switches.
   assign raw_all = {bus.button_raw, bus.switches_raw};

   for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_r;
      logic                   s;
      logic [0:0]             state;
      logic [CNT_W-1:0]       cnt;
      logic                   q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_r <= '0;
         end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_all[ch]};
         end
      end

      assign s = sync_r[SYNC_STAGES-1];

      // A new level is accepted only after it has differed from q for
      // DEBOUNCE_CYCLES consecutive samples; any return to q restarts the wait.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            q     <= 1'b0;
         end else begin
            case (state)
               STABLE: begin
                  cnt <= '0;
                  if (s != q) begin
                     if (IMMEDIATE) begin
                        q <= s;
                     end else begin
                        state <= PENDING;
                        cnt   <= CNT_W'(1);
                     end
                  end
               end
               PENDING: begin
                  if (s == q) begin
                     state <= STABLE;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     q     <= s;
                     state <= STABLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= STABLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign level[ch] = q;
   end

   // Set has priority over ack so a press arriving alongside a clear is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         button_q_d <= 1'b0;
         rise_r     <= 1'b0;
         pressed_r  <= 1'b0;
      end else begin
         button_q_d <= level[NCH-1];
         rise_r     <= level[NCH-1] & ~button_q_d;
         if (rise_r) begin
            pressed_r <= 1'b1;
         end else if (bus.ack) begin
            pressed_r <= 1'b0;
         end
      end
   end

   assign bus.button_1       = level[NCH-1];
   assign bus.switches       = level[3:0];
   assign bus.button_rise    = rise_r;
   assign bus.button_pressed = pressed_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// expectations are queued with a target edge count when stimulus is applied.
module tb_input_conditioner;

   localparam int SEL_B1    = 0;
   localparam int SEL_SW    = 1;
   localparam int SEL_RISE  = 2;
   localparam int SEL_PRESS = 3;

   typedef struct {
      string      tag;
      int         sel;
      logic [3:0] exp;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   edges = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   input_conditioner_if bus();

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at edge %0d", tag, got, exp, edges);
      end
   endtask

   function automatic logic [3:0] observe(input int sel);
      case (sel)
         SEL_B1:    return {3'b000, bus.button_1};
         SEL_SW:    return bus.switches;
         SEL_RISE:  return {3'b000, bus.button_rise};
         default:   return {3'b000, bus.button_pressed};
      endcase
   endfunction

   // Outputs are sampled on the falling edge, half a period after the active edge.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= edges) begin
            checkOutput(sb[i].tag, observe(sb[i].sel), sb[i].exp);
            sb.delete(i);
         end
      end
   end

   task automatic expectAt(input string tag, input int sel, input logic [3:0] val, input int offset);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = val;
      e.cyc = edges + offset;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic btn, input logic [3:0] sw, input logic ackv);
      bus.button_raw   = btn;
      bus.switches_raw = sw;
      bus.ack          = ackv;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput($sformatf("%s_b1", tag), {3'b000, bus.button_1}, 4'h0);
      checkOutput($sformatf("%s_sw", tag), bus.switches, 4'h0);
      checkOutput($sformatf("%s_rise", tag), {3'b000, bus.button_rise}, 4'h0);
      checkOutput($sformatf("%s_press", tag), {3'b000, bus.button_pressed}, 4'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (2) tick();
      checkResetState("t1_rst");
      rst_n = 1'b1;
      tick();

      // Clean button press: level after 6 edges, pulse on the 7th, sticky on the 8th.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      expectAt("t1_b1_early", SEL_B1, 4'h0, 5);
      expectAt("t1_b1", SEL_B1, 4'h1, 6);
      expectAt("t1_rise_pre", SEL_RISE, 4'h0, 6);
      expectAt("t1_rise", SEL_RISE, 4'h1, 7);
      expectAt("t1_rise_end", SEL_RISE, 4'h0, 8);
      expectAt("t1_press_pre", SEL_PRESS, 4'h0, 7);
      expectAt("t1_press", SEL_PRESS, 4'h1, 8);
      repeat (10) tick();

      // Release: level drops after 6 edges, no pulse, sticky flag untouched.
      applyStimulus(1'b0, 4'b0000, 1'b0);
      expectAt("t6_b1_early", SEL_B1, 4'h1, 5);
      expectAt("t6_b1", SEL_B1, 4'h0, 6);
      expectAt("t6_rise_a", SEL_RISE, 4'h0, 6);
      expectAt("t6_rise_b", SEL_RISE, 4'h0, 7);
      expectAt("t6_rise_c", SEL_RISE, 4'h0, 8);
      expectAt("t6_press_a", SEL_PRESS, 4'h1, 8);
      expectAt("t6_press_b", SEL_PRESS, 4'h1, 10);
      repeat (12) tick();

      // Ack clears the flag next cycle; ack while clear has no effect.
      applyStimulus(1'b0, 4'b0000, 1'b1);
      expectAt("t3_press_held", SEL_PRESS, 4'h1, 0);
      expectAt("t3_press_clr", SEL_PRESS, 4'h0, 1);
      tick();
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (2) tick();
      applyStimulus(1'b0, 4'b0000, 1'b1);
      expectAt("t3_ack_idle_a", SEL_PRESS, 4'h0, 1);
      expectAt("t3_ack_idle_b", SEL_PRESS, 4'h0, 2);
      tick();
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (3) tick();

      // Three-cycle glitch is shorter than the debounce window and must vanish.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      expectAt("t2_b1_a", SEL_B1, 4'h0, 3);
      expectAt("t2_b1_b", SEL_B1, 4'h0, 5);
      expectAt("t2_b1_c", SEL_B1, 4'h0, 6);
      expectAt("t2_b1_d", SEL_B1, 4'h0, 7);
      expectAt("t2_b1_e", SEL_B1, 4'h0, 9);
      expectAt("t2_rise_a", SEL_RISE, 4'h0, 7);
      expectAt("t2_rise_b", SEL_RISE, 4'h0, 8);
      expectAt("t2_press", SEL_PRESS, 4'h0, 10);
      repeat (3) tick();
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (10) tick();

      // Ack in the same cycle as the rise pulse: set wins.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      expectAt("t3b_rise", SEL_RISE, 4'h1, 7);
      expectAt("t3b_press_pre", SEL_PRESS, 4'h0, 7);
      expectAt("t3b_press_set", SEL_PRESS, 4'h1, 8);
      expectAt("t3b_press_keep", SEL_PRESS, 4'h1, 9);
      repeat (7) tick();
      applyStimulus(1'b1, 4'b0000, 1'b1);
      tick();
      applyStimulus(1'b1, 4'b0000, 1'b0);
      repeat (3) tick();
      applyStimulus(1'b1, 4'b0000, 1'b1);
      expectAt("t3b_press_clr", SEL_PRESS, 4'h0, 1);
      tick();
      applyStimulus(1'b0, 4'b0000, 1'b0);
      repeat (10) tick();

      // Switches: bit3 clean, bit1 bounces 1,0,1 and settles two cycles later.
      applyStimulus(1'b0, 4'b1010, 1'b0);
      expectAt("t4_sw_a", SEL_SW, 4'b0000, 5);
      expectAt("t4_sw_b", SEL_SW, 4'b1000, 6);
      expectAt("t4_sw_c", SEL_SW, 4'b1000, 7);
      expectAt("t4_sw_d", SEL_SW, 4'b1010, 8);
      expectAt("t4_rise", SEL_RISE, 4'h0, 8);
      tick();
      applyStimulus(1'b0, 4'b1000, 1'b0);
      tick();
      applyStimulus(1'b0, 4'b1010, 1'b0);
      repeat (10) tick();

      // Reset is asynchronous; inputs held high across release settle normally.
      applyStimulus(1'b1, 4'b1010, 1'b0);
      rst_n = 1'b0;
      #1;
      checkResetState("t5_rst");
      repeat (2) tick();
      rst_n = 1'b1;
      expectAt("t5_b1_early", SEL_B1, 4'h0, 5);
      expectAt("t5_b1", SEL_B1, 4'h1, 6);
      expectAt("t5_sw_early", SEL_SW, 4'b0000, 5);
      expectAt("t5_sw", SEL_SW, 4'b1010, 6);
      expectAt("t5_rise_pre", SEL_RISE, 4'h0, 6);
      expectAt("t5_rise", SEL_RISE, 4'h1, 7);
      expectAt("t5_rise_end", SEL_RISE, 4'h0, 8);
      expectAt("t5_rise_late_a", SEL_RISE, 4'h0, 9);
      expectAt("t5_rise_late_b", SEL_RISE, 4'h0, 12);
      expectAt("t5_press", SEL_PRESS, 4'h1, 8);
      repeat (14) tick();

      // Reset during a pending 1->0 change discards the count.
      applyStimulus(1'b0, 4'b1010, 1'b0);
      expectAt("t5_pend_b1", SEL_B1, 4'h1, 3);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      checkResetState("t5_midrst");
      applyStimulus(1'b1, 4'b0000, 1'b0);
      tick();
      rst_n = 1'b1;
      expectAt("t5_restart_early", SEL_B1, 4'h0, 5);
      expectAt("t5_restart", SEL_B1, 4'h1, 6);
      repeat (10) tick();

      checkOutput("sb_drain", 4'(sb.size()), 4'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
